match_ctrl: RTL
===============

MATCH_CTRL -- requirements
Module: match_ctrl

Interface
REQ-001 Parameter WIN_SCORE, default 7: points needed to win a match (1-15).
REQ-002 Parameter SERVE_FRAMES, default 60: frame ticks spent in SERVE before ball release.
REQ-003 Parameter POINT_FRAMES, default 90: frame ticks of freeze after a point.
REQ-004 Parameter SCREEN_W, default 640: playfield width in pixels.
REQ-005 Port clk  in  1  single system clock; all state changes on its rising edge.
REQ-006 Port reset  in  1  asynchronous, active-high reset.
REQ-007 Port frame_tick  in  1  one-clk pulse per video frame.
REQ-008 Port start_btn  in  1  raw, asynchronous start pushbutton, active-high.
REQ-009 Port ball_x  in  10  ball upper-left X.
REQ-010 Port ball_width  in  6  ball width in pixels.
REQ-011 Port obj_hold  out  1  holds paddles and ball at their reset positions.
REQ-012 Port ball_en  out  1  ball motion enable.
REQ-013 Port serve_dir  out  1  initial ball direction: 1 = toward left paddle, 0 = toward right.
REQ-014 Port score_l, score_r  out  4 each  left and right scores.
REQ-015 Port winner  out  2  00 none, 10 left won, 01 right won.
REQ-016 Port state_led  out  3  current state code for board LEDs.

Function
REQ-017 States: IDLE(0), SERVE(1), PLAY(2), POINT(3), GAMEOVER(4); state_led SHALL equal the code.
REQ-018 start_btn SHALL pass through a 2-flop synchroniser; a "start" event SHALL be the rising edge of the synchronised signal (one clk).
REQ-019 IDLE -> SERVE on start; scores cleared to 0 and serve_dir set to 1 on that transition.
REQ-020 SERVE: frame counter cleared on entry, incremented per frame_tick; on the tick that makes it equal SERVE_FRAMES -> PLAY.
REQ-021 PLAY: miss evaluated only on frame_tick cycles; ball_x == 0 -> right scores; ball_x + ball_width >= SCREEN_W (11-bit compare, no wrap) -> left scores; both true -> left-edge miss takes priority.
REQ-022 On a miss: the scoring side's score increments (saturating at WIN_SCORE); serve_dir set toward the conceding side (right scores -> 1, left scores -> 0); -> POINT.
REQ-023 POINT: frame counter cleared on entry; after POINT_FRAMES ticks -> GAMEOVER if either score == WIN_SCORE, else -> SERVE.
REQ-024 GAMEOVER: winner driven from scores; scores held; start -> SERVE with scores cleared, winner = 00, serve_dir = 1.
REQ-025 obj_hold = 1 in IDLE, SERVE, GAMEOVER; 0 in PLAY and POINT (objects frozen in place, not recentred, during POINT).
REQ-026 ball_en = 1 only in PLAY; all outputs registered (one clk after the state change).
REQ-027 Start events outside IDLE and GAMEOVER SHALL be ignored.
REQ-028 frame_tick absent: counters and state SHALL hold indefinitely (no clk-based timeout).
REQ-029 Frame counter width: 7 bits, sufficient for max(SERVE_FRAMES, POINT_FRAMES) <= 127.

Reset
REQ-030 On reset: state IDLE, counter 0, synchroniser flops 0, score_l = score_r = 0, winner = 00, serve_dir = 1, obj_hold = 1, ball_en = 0, state_led = 0.
REQ-031 Reset asserted mid-match (any state) SHALL abort immediately to the reset values; a held start_btn across reset release SHALL NOT produce a start event.

Structure
REQ-032 State codes, side encoding (LEFT = 1, RIGHT = 0), SCREEN_W and SCREEN_H (480) SHALL live in the shared pong definitions package/include, also used by paddle and ball.
REQ-033 The synchroniser plus rising-edge detector SHALL be a sub-module btn_edge, reusable for other buttons.

Verification
REQ-034 Reset, press start, 60 frame ticks -> SERVE for exactly 60 ticks, then PLAY with ball_en = 1, serve_dir = 1.
REQ-035 PLAY, ball_x = 0 on frame_tick -> score_r = 1, serve_dir = 1, POINT; after 90 ticks -> SERVE, obj_hold = 1.
REQ-036 PLAY, ball_x = 632, ball_width = 8 on frame_tick -> score_l increments, serve_dir = 0; ball_x = 631 -> no change.
REQ-037 score_l = 6, left-scoring miss -> score_l = 7, after 90 ticks GAMEOVER, winner = 10; start -> scores 0, SERVE.
REQ-038 start pulsed during PLAY and POINT -> no state change; ball_x = 0 without frame_tick -> no score.
REQ-039 Reset asserted in PLAY with score 3-2, start_btn held high through release -> IDLE, scores 0, no start until button released and re-pressed.

Source files
------------

// File: rtl/match_ctrl_pkg.sv
// Shared pong definitions: state codes, side encoding and playfield geometry.
// Also used by the paddle and ball blocks.
package match_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SERVE    = 3'd1,
        ST_PLAY     = 3'd2,
        ST_POINT    = 3'd3,
        ST_GAMEOVER = 3'd4
    } state_t;

    localparam logic SIDE_LEFT  = 1'b1;
    localparam logic SIDE_RIGHT = 1'b0;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

    localparam int FRAME_CNT_W = 7;

    function automatic logic [3:0] sat_inc(input logic [3:0] v, input logic [3:0] lim);
        return (v < lim) ? v + 4'd1 : v;
    endfunction

endpackage

// File: rtl/match_ctrl_btn_edge.sv
// Two-flop synchroniser plus one-clk rising-edge detector for a raw pushbutton.
// A button already held when reset releases must be let go before it can fire.
module btn_edge (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic rise
);

    logic sync1, sync2, prev;
    logic valid1, valid2, armed;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            prev   <= 1'b0;
            valid1 <= 1'b0;
            valid2 <= 1'b0;
            armed  <= 1'b0;
        end else begin
            sync1  <= btn;
            sync2  <= sync1;
            prev   <= sync2;
            valid1 <= 1'b1;
            valid2 <= valid1;
            // arm only once the pipeline holds a real sample showing the button low
            if (valid2 && !sync2)
                armed <= 1'b1;
        end
    end

    assign rise = armed & sync2 & ~prev;

endmodule

// File: rtl/match_ctrl.sv
// Match sequencing for pong: serve delay, miss detection, scoring,
// point freeze and game-over, with registered board outputs.
module match_ctrl #(
    parameter int WIN_SCORE    = 7,
    parameter int SERVE_FRAMES = 60,
    parameter int POINT_FRAMES = 90,
    parameter int SCREEN_W     = match_ctrl_pkg::SCREEN_W
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       start_btn,
    input  logic [9:0] ball_x,
    input  logic [5:0] ball_width,
    output logic       obj_hold,
    output logic       ball_en,
    output logic       serve_dir,
    output logic [3:0] score_l,
    output logic [3:0] score_r,
    output logic [1:0] winner,
    output logic [2:0] state_led
);

    import match_ctrl_pkg::*;

    localparam logic [3:0]             WIN        = 4'(WIN_SCORE);
    localparam logic [FRAME_CNT_W-1:0] SERVE_LAST = FRAME_CNT_W'(SERVE_FRAMES);
    localparam logic [FRAME_CNT_W-1:0] POINT_LAST = FRAME_CNT_W'(POINT_FRAMES);
    localparam logic [10:0]            RIGHT_LIM  = 11'(SCREEN_W);

    state_t                 state_q, state_d;
    logic [FRAME_CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [3:0]             sl_q, sl_d, sr_q, sr_d;
    logic                   dir_q, dir_d;
    logic                   start;
    logic                   miss_l, miss_r;
    logic [10:0]            ball_right;

    btn_edge u_start (
        .clk   (clk),
        .reset (reset),
        .btn   (start_btn),
        .rise  (start)
    );

    assign ball_right = {1'b0, ball_x} + {5'b0, ball_width};
    assign miss_l     = (ball_x == 10'd0);
    assign miss_r     = (ball_right >= RIGHT_LIM);
    assign cnt_inc    = cnt_q + 1'b1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sl_d    = sl_q;
        sr_d    = sr_q;
        dir_d   = dir_q;
        case (state_q)
            ST_IDLE, ST_GAMEOVER: begin
                if (start) begin
                    state_d = ST_SERVE;
                    cnt_d   = '0;
                    sl_d    = '0;
                    sr_d    = '0;
                    dir_d   = SIDE_LEFT;
                end
            end
            ST_SERVE: begin
                if (frame_tick) begin
                    if (cnt_inc == SERVE_LAST) begin
                        state_d = ST_PLAY;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            ST_PLAY: begin
                // left-edge miss wins when both edges are crossed
                if (frame_tick && miss_l) begin
                    sr_d    = sat_inc(sr_q, WIN);
                    dir_d   = SIDE_LEFT;
                    state_d = ST_POINT;
                    cnt_d   = '0;
                end else if (frame_tick && miss_r) begin
                    sl_d    = sat_inc(sl_q, WIN);
                    dir_d   = SIDE_RIGHT;
                    state_d = ST_POINT;
                    cnt_d   = '0;
                end
            end
            ST_POINT: begin
                if (frame_tick) begin
                    if (cnt_inc == POINT_LAST) begin
                        cnt_d   = '0;
                        state_d = (sl_q == WIN || sr_q == WIN) ? ST_GAMEOVER : ST_SERVE;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            sl_q    <= '0;
            sr_q    <= '0;
            dir_q   <= SIDE_LEFT;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sl_q    <= sl_d;
            sr_q    <= sr_d;
            dir_q   <= dir_d;
        end
    end

    // board outputs are decoded from the state register and lag it by one clk
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            obj_hold  <= 1'b1;
            ball_en   <= 1'b0;
            state_led <= '0;
            winner    <= '0;
        end else begin
            obj_hold  <= (state_q != ST_PLAY) && (state_q != ST_POINT);
            ball_en   <= (state_q == ST_PLAY);
            state_led <= state_q;
            winner    <= (state_q == ST_GAMEOVER) ? {sl_q == WIN, sr_q == WIN} : 2'b00;
        end
    end

    assign score_l   = sl_q;
    assign score_r   = sr_q;
    assign serve_dir = dir_q;

endmodule
